// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register driver: command modes,
// register select codes and the driver state type.
package shift_reg_pkg;

    localparam logic [1:0] MODE_WR_RIGHT = 2'd0;
    localparam logic [1:0] MODE_WR_LEFT  = 2'd1;
    localparam logic [1:0] MODE_INVERT   = 2'd2;
    localparam logic [1:0] MODE_READBACK = 2'd3;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_INV  = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_SHL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_INV   = 2'd2,
        ST_DONE  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/shift_reg_driver.sv
// Serial initiator for the universal shift register: loads, inverts or reads
// back the register one bit per cycle and returns its previous contents.
module shift_reg_driver
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic [1:0]       select,
    output logic             s_right_din,
    output logic             s_left_din,
    input  logic             s_left_dout,
    input  logic             s_right_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    drv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] cap_q, cap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_WR_RIGHT;
            data_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
        end
    end

    // Capture follows the shift direction so the old word ends up in its
    // natural bit order after WIDTH shifts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        cap_d   = cap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = (in_mode == MODE_INVERT) ? ST_INV : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mode_q == MODE_WR_LEFT) begin
                    cap_d = {cap_q[WIDTH-2:0], s_right_dout};
                end else begin
                    cap_d = {s_left_dout, cap_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_INV: begin
                state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        select      = SEL_HOLD;
        s_right_din = 1'b0;
        s_left_din  = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                // Readback feeds bit 0 straight back into the MSB, a full rotate.
                unique case (mode_q)
                    MODE_WR_LEFT: begin
                        select     = SEL_SHL;
                        s_left_din = data_q[LAST_CNT - cnt_q];
                    end
                    MODE_READBACK: begin
                        select      = SEL_SHR;
                        s_right_din = s_left_dout;
                    end
                    default: begin
                        select      = SEL_SHR;
                        s_right_din = data_q[cnt_q];
                    end
                endcase
            end
            ST_INV: begin
                select = SEL_INV;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = cap_q;
            end
            default: begin
                select = SEL_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_driver.sv
// Self-checking bench: the driver controls a behavioural 4-bit universal
// register; results are compared against a table and a word-level model.
module tb_shift_reg_driver;
    import shift_reg_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [W-1:0] in_data;
    logic [1:0]   select;
    logic         s_right_din;
    logic         s_left_din;
    logic         s_left_dout;
    logic         s_right_dout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    logic [W-1:0] plantReg;
    logic [W-1:0] modelReg;
    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] data;
        logic [W-1:0] expOut;
        logic [W-1:0] expReg;
        bit           expValid;
        int           hold;
    } vec_t;

    vec_t vecs[4];

    shift_reg_driver #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .select       (select),
        .s_right_din  (s_right_din),
        .s_left_din   (s_left_din),
        .s_left_dout  (s_left_dout),
        .s_right_dout (s_right_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // The controlled register; not reset, so aborted loads leave partial contents.
    always @(posedge clk) begin
        case (select)
            SEL_INV: plantReg <= ~plantReg;
            SEL_SHR: plantReg <= {s_right_din, plantReg[W-1:1]};
            SEL_SHL: plantReg <= {plantReg[W-2:0], s_left_din};
            default: plantReg <= plantReg;
        endcase
    end

    assign s_left_dout  = plantReg[0];
    assign s_right_dout = plantReg[W-1];

    function automatic logic [1:0] expSel(input logic [1:0] mode);
        if (mode == MODE_WR_LEFT) return SEL_SHL;
        if (mode == MODE_INVERT)  return SEL_INV;
        return SEL_SHR;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] mode,
                                 input logic [W-1:0] data);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, " ready wait"}, (guard < 50), 1);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic doCommand(input string tag, input logic [1:0] mode,
                             input logic [W-1:0] data, input logic [W-1:0] expOut,
                             input bit expValid, input logic [W-1:0] expReg,
                             input int hold);
        bit           gotValid = 0;
        bit           selOk = 1;
        bit           unusedOk = 1;
        int           shiftCycles = 0;
        int           invCycles = 0;
        int           latency = 0;
        int           readyAt = 0;
        logic [W-1:0] bits = '0;
        logic [W-1:0] gotData = '0;

        applyStimulus(tag, mode, data);
        for (int c = 1; c <= 3 * W; c++) begin
            @(negedge clk);
            if (out_valid) begin
                gotValid = 1;
                latency  = c;
                gotData  = out_data;
                break;
            end
            if (in_ready) begin
                readyAt = c;
                break;
            end
            if (select == SEL_INV) begin
                invCycles++;
            end else if (select != SEL_HOLD) begin
                if (select != expSel(mode)) selOk = 0;
                if (shiftCycles < W) begin
                    if (select == SEL_SHL) begin
                        bits[W-1-shiftCycles] = s_left_din;
                        if (s_right_din) unusedOk = 0;
                    end else begin
                        bits[shiftCycles] = s_right_din;
                        if (s_left_din) unusedOk = 0;
                    end
                end
                shiftCycles++;
            end
        end

        checkOutput({tag, " out_valid"}, gotValid, expValid);
        checkOutput({tag, " select code"}, selOk, 1);
        if (expValid) begin
            checkOutput({tag, " shift cycles"}, shiftCycles, W);
            checkOutput({tag, " serial bits"}, bits,
                        (mode == MODE_READBACK) ? expOut : data);
            checkOutput({tag, " unused serial bit"}, unusedOk, 1);
            checkOutput({tag, " latency"}, latency, W + 1);
            checkOutput({tag, " out_data"}, gotData, expOut);
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_mode  = MODE_INVERT;
                in_data  = W'($urandom);
                @(negedge clk);
                checkOutput({tag, " hold valid"}, out_valid, 1);
                checkOutput({tag, " hold data"}, out_data, gotData);
                checkOutput({tag, " hold in_ready"}, in_ready, 0);
                checkOutput({tag, " hold select"}, select, SEL_HOLD);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkOutput({tag, " idle after consume"}, {busy, in_ready, out_valid}, 3'b010);
        end else begin
            checkOutput({tag, " invert cycles"}, invCycles, 1);
            checkOutput({tag, " ready return"}, readyAt, 2);
        end
        checkOutput({tag, " register"}, plantReg, expReg);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]   rMode;
        logic [W-1:0] rData;
        logic [W-1:0] rExp;
        int           rHold;

        vecs[0] = '{MODE_WR_RIGHT, 4'b1011, 4'b0000, 4'b1011, 1'b1, 0};
        vecs[1] = '{MODE_WR_LEFT,  4'b0110, 4'b1011, 4'b0110, 1'b1, 0};
        vecs[2] = '{MODE_INVERT,   4'b0000, 4'b0000, 4'b1001, 1'b0, 0};
        vecs[3] = '{MODE_READBACK, 4'b0000, 4'b1001, 4'b1001, 1'b1, 3};

        plantReg  = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = MODE_WR_RIGHT;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        checkOutput("reset select", select, SEL_HOLD);
        checkOutput("reset serial", {s_right_din, s_left_din}, 2'b00);
        checkOutput("reset flags", {busy, in_ready, out_valid}, 3'b010);
        checkOutput("reset out_data", out_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 4; i++) begin
            doCommand($sformatf("vec%0d", i), vecs[i].mode, vecs[i].data, vecs[i].expOut,
                      vecs[i].expValid, vecs[i].expReg, vecs[i].hold);
        end
        modelReg = vecs[3].expReg;

        $display("[TB] random commands");
        for (int i = 0; i < 12; i++) begin
            rMode = 2'($urandom_range(0, 3));
            rData = W'($urandom);
            rHold = $urandom_range(0, 2);
            if (rMode == MODE_INVERT)        rExp = ~modelReg;
            else if (rMode == MODE_READBACK) rExp = modelReg;
            else                             rExp = rData;
            doCommand($sformatf("rnd%0d", i), rMode, rData, modelReg,
                      (rMode != MODE_INVERT), rExp, rHold);
            modelReg = rExp;
        end

        $display("[TB] reset during shift");
        doCommand("clear", MODE_WR_RIGHT, 4'b0000, modelReg, 1'b1, 4'b0000, 0);
        applyStimulus("abort", MODE_WR_RIGHT, 4'b1111);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort select", select, SEL_HOLD);
        checkOutput("abort flags", {busy, out_valid}, 2'b00);
        checkOutput("abort register", plantReg, 4'b1100);
        @(negedge clk);
        rst = 1'b0;
        doCommand("post-abort readback", MODE_READBACK, 4'b0000, 4'b1100, 1'b1, 4'b1100, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
